// File: rtl/alu_pipe.sv
// alu_pipe: two-stage handshaked ALU with a 2*WIDTH result plus zero and error flags.
// Latency: 1 edge after acceptance for most ops; WIDTH+2 edges for a divide with b != 0.
// Backpressure: S2 holds while out_ready is low, S1 then holds, and in_ready drops once both are full.
//
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready      operation handshake carrying a, b (WIDTH) and alu_sel (4)
//   out_valid / out_ready    result handshake carrying out (2*WIDTH), out_zero, out_err
//
// Build option: define ALU_PIPE_DIV_EN to include the iterative restoring divider.
// Without it, opcode 0011 completes at the normal latency with out all ones and out_err set.

module alu_pipe #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         alu_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               out_zero,
  output logic               out_err
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHR  = 4'b0100;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_XNOR = 4'b1011;
  localparam logic [3:0] OP_MAX  = 4'b1100;
  localparam logic [3:0] OP_EQ   = 4'b1101;
  localparam logic [3:0] OP_MIN  = 4'b1110;
  localparam logic [3:0] OP_SLT  = 4'b1111;

  // ---------------------------------------------------------------------------
  // Stage S1: operand / opcode register
  // ---------------------------------------------------------------------------
  logic             s1_vld;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_sel;

  logic s1_res_rdy;   // S1 holds a finished result this cycle
  logic s2_load_ok;   // S2 is empty or draining this cycle
  logic s1_xfer;      // S1 -> S2 move at the next edge
  logic in_fire;

  assign s2_load_ok = !out_valid || out_ready;
  assign s1_xfer    = s1_vld && s1_res_rdy && s2_load_ok;
  // Independent of in_valid so the producer never sees a combinational loop.
  assign in_ready   = !s1_vld || s1_xfer;
  assign in_fire    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_sel <= '0;
    end else if (in_fire) begin
      // Load and transfer can coincide; the load wins and keeps full throughput.
      s1_vld <= 1'b1;
      s1_a   <= a;
      s1_b   <= b;
      s1_sel <= alu_sel;
    end else if (s1_xfer) begin
      s1_vld <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Divide path
  // ---------------------------------------------------------------------------
  logic [W2-1:0] div_res;
  logic          div_err;

`ifdef ALU_PIPE_DIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] div_rem_q;
  logic [WIDTH-1:0] div_quo_q;   // holds the dividend, shifted out as quotient bits shift in
  logic [SHW-1:0]   div_cnt_q;
  logic             div_start;
  logic             div_last;
  logic             div_by_zero;
  logic             long_div;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;

  assign div_by_zero = (s1_b == '0);
  // b == 0 is answered directly at normal latency; only real divides iterate.
  assign long_div    = s1_vld && (s1_sel == OP_DIV) && !div_by_zero;
  assign div_last    = (div_cnt_q == SHW'(WIDTH - 1));

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder stays below b, so diff[WIDTH] is set exactly when trial < b.
  assign div_trial = {div_rem_q, div_quo_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, s1_b};

  always_comb begin
    state_d    = state_q;
    s1_res_rdy = 1'b0;
    div_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (long_div) begin
          state_d   = ST_DIV;
          div_start = 1'b1;
        end else begin
          s1_res_rdy = s1_vld;
        end
      end
      ST_DIV: begin
        if (div_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        s1_res_rdy = 1'b1;
        if (s2_load_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      div_rem_q <= '0;
      div_quo_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (div_start) begin
        div_rem_q <= '0;
        div_quo_q <= s1_a;
        div_cnt_q <= '0;
      end else if (state_q == ST_DIV) begin
        if (!div_diff[WIDTH]) begin
          div_rem_q <= div_diff[WIDTH-1:0];
          div_quo_q <= {div_quo_q[WIDTH-2:0], 1'b1};
        end else begin
          div_rem_q <= div_trial[WIDTH-1:0];
          div_quo_q <= {div_quo_q[WIDTH-2:0], 1'b0};
        end
        div_cnt_q <= div_cnt_q + 1'b1;
      end
    end
  end

  assign div_res = div_by_zero ? {s1_a, {WIDTH{1'b1}}} : {div_rem_q, div_quo_q};
  assign div_err = div_by_zero;
`else
  // No divider: every op, including 0011, is ready as soon as it sits in S1.
  assign s1_res_rdy = s1_vld;
  assign div_res    = '1;
  assign div_err    = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Result datapath (combinational from S1)
  // ---------------------------------------------------------------------------
  logic [W2-1:0] a_ext;
  logic [W2-1:0] b_ext;
  logic [SHW:0]  shamt;   // one extra bit so shifts reach 2*WIDTH-1
  logic [W2-1:0] res;
  logic          res_err;

  assign a_ext = {{WIDTH{1'b0}}, s1_a};
  assign b_ext = {{WIDTH{1'b0}}, s1_b};
  assign shamt = s1_b[SHW:0];

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (s1_sel)
      OP_ADD:  res = a_ext + b_ext;
      OP_SUB:  res = a_ext - b_ext;      // borrow propagates into the upper half
      OP_MUL:  res = a_ext * b_ext;
      OP_DIV: begin
        res     = div_res;
        res_err = div_err;
      end
      OP_SHR:  res = a_ext >> shamt;
      OP_SHL:  res = a_ext << shamt;
      OP_AND:  res = {{WIDTH{1'b0}}, s1_a & s1_b};
      OP_OR:   res = {{WIDTH{1'b0}}, s1_a | s1_b};
      OP_NAND: res = {{WIDTH{1'b0}}, ~(s1_a & s1_b)};
      OP_NOR:  res = {{WIDTH{1'b0}}, ~(s1_a | s1_b)};
      OP_XOR:  res = {{WIDTH{1'b0}}, s1_a ^ s1_b};
      OP_XNOR: res = {{WIDTH{1'b0}}, ~(s1_a ^ s1_b)};
      OP_MAX:  res = (s1_a > s1_b) ? a_ext : b_ext;
      OP_EQ:   res = {{(W2-1){1'b0}}, (s1_a == s1_b)};
      OP_MIN:  res = (s1_a < s1_b) ? a_ext : b_ext;
      OP_SLT:  res = {{(W2-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      default: res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage S2: result register and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_zero  <= 1'b0;
      out_err   <= 1'b0;
    end else if (s1_xfer) begin
      out_valid <= 1'b1;
      out       <= res;
      out_zero  <= (res == '0);
      out_err   <= res_err;
    end else if (out_ready) begin
      // Data is left in place after a drain; only the valid flag drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  alu_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out;
  logic        out_zero;
  logic        out_err;

  alu_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] o;
    logic        z;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference behaviour of one operation.
  function automatic exp_t model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    logic        e;
    r = '0;
    e = 1'b0;
    case (s)
      4'd0:  r = {32'b0, x} + {32'b0, y};
      4'd1:  r = {32'b0, x} - {32'b0, y};
      4'd2:  r = {32'b0, x} * {32'b0, y};
      4'd3: begin
`ifdef ALU_PIPE_DIV_EN
        if (y == 32'd0) begin
          r = {x, 32'hFFFF_FFFF};
          e = 1'b1;
        end else begin
          r = {x % y, x / y};
        end
`else
        r = '1;
        e = 1'b1;
`endif
      end
      4'd4:  r = {32'b0, x} >> y[5:0];
      4'd5:  r = {32'b0, x} << y[5:0];
      4'd6:  r = {32'b0, x & y};
      4'd7:  r = {32'b0, x | y};
      4'd8:  r = {32'b0, ~(x & y)};
      4'd9:  r = {32'b0, ~(x | y)};
      4'd10: r = {32'b0, x ^ y};
      4'd11: r = {32'b0, ~(x ^ y)};
      4'd12: r = (x > y) ? {32'b0, x} : {32'b0, y};
      4'd13: r = {63'b0, (x == y)};
      4'd14: r = (x < y) ? {32'b0, x} : {32'b0, y};
      default: r = {63'b0, ($signed(x) < $signed(y))};
    endcase
    return {r, (r == 64'd0), e};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one op, wait (bounded) for acceptance, record its expected result.
  task automatic send(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    int n;
    n        = 0;
    in_valid = 1'b1;
    alu_sel  = s;
    a        = x;
    b        = y;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", {63'b0, in_ready}, 64'd1);
    sb.push_back(model(s, x, y));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges from the acceptance edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: every output handshake pops and compares the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_assert++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_spurious: observed %h expected no output", out);
        end
      end else begin
        e = sb.pop_front();
        chk("sb_out", out, e.o);
        chk("sb_zero", {63'b0, out_zero}, {63'b0, e.z});
        chk("sb_err", {63'b0, out_err}, {63'b0, e.e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   hi;
    int   acc;
    int   bad;
    logic have;
    logic [63:0] snap;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out", out, 64'd0);
    chk("rst_out_zero", {63'b0, out_zero}, 64'd0);
    chk("rst_out_err", {63'b0, out_err}, 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back add then multiply, one edge latency each
    send(4'd0, 32'hFFFF_FFFF, 32'd1);
    send(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("add_lat1_valid", {63'b0, out_valid}, 64'd1);
    chk("add_out", out, 64'h0000_0001_0000_0000);
    @(posedge clk);
    #1;
    chk("mul_next_valid", {63'b0, out_valid}, 64'd1);
    chk("mul_out", out, 64'hFFFF_FFFE_0000_0001);
    drain();

    // Shift boundaries
    send(4'd5, 32'd1, 32'd63);
    wait_valid(lat);
    chk("shl_lat", 64'(lat), 64'd1);
    chk("shl_out", out, 64'h8000_0000_0000_0000);
    drain();
    send(4'd4, 32'h8000_0000, 32'd32);
    wait_valid(lat);
    chk("shr_out", out, 64'd0);
    chk("shr_zero", {63'b0, out_zero}, 64'd1);
    drain();

    // Borrow and signed compare
    send(4'd1, 32'd1, 32'd2);
    send(4'd15, 32'hFFFF_FFFF, 32'd1);
    drain();

    // Divide
`ifdef ALU_PIPE_DIV_EN
    send(4'd3, 32'd100, 32'd7);
    lat = 0;
    hi  = in_ready ? 1 : 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid && lat <= 32 && in_ready) hi++;
    end
    chk("div_lat", 64'(lat), 64'd34);
    chk("div_in_ready_low", 64'(hi), 64'd0);
    chk("div_out", out, {32'd2, 32'd14});
    chk("div_err", {63'b0, out_err}, 64'd0);
    drain();
    send(4'd3, 32'd100, 32'd0);
    wait_valid(lat);
    chk("div0_lat", 64'(lat), 64'd1);
    chk("div0_out", out, {32'd100, 32'hFFFF_FFFF});
    chk("div0_err", {63'b0, out_err}, 64'd1);
    drain();
`else
    send(4'd3, 32'd9, 32'd3);
    wait_valid(lat);
    chk("nodiv_lat", 64'(lat), 64'd1);
    chk("nodiv_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("nodiv_err", {63'b0, out_err}, 64'd1);
    drain();
`endif

    // Every opcode once with random operands
    for (int i = 0; i < 16; i++) begin
      send(4'(i), $urandom, $urandom);
    end
    drain();

    // Backpressure: 5 cycles of offered 0110 ops with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_sel   = 4'd6;
    b         = 32'h0F0F_0F0F;
    acc  = 0;
    bad  = 0;
    have = 1'b0;
    snap = '0;
    for (int c = 0; c < 5; c++) begin
      a = 32'hA5A5_0000 + 32'(c);
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(4'd6, a, b));
        acc++;
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (!have) begin
          snap = out;
          have = 1'b1;
        end else if (out !== snap) begin
          bad++;
        end
      end
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
    chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_stable", 64'(bad), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with both stages occupied (mid-divide when the divider exists)
    out_ready = 1'b0;
    send(4'd7, 32'd1, 32'd2);
`ifdef ALU_PIPE_DIV_EN
    send(4'd3, 32'd1000, 32'd3);
`else
    send(4'd6, 32'd3, 32'd5);
`endif
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_valid", {63'b0, out_valid}, 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_out", out, 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(4'd0, 32'd5, 32'd6);
    wait_valid(lat);
    chk("post_rst_lat", 64'(lat), 64'd1);
    chk("post_rst_out", out, 64'd11);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
